alu_exec_unit: RTL and testbench

//  Execution-side consumer of the decoder's alu_control/regwrite_control pair.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_exec_unit_if.sv | 22 ++
 rtl/alu_mul_iter.sv | 72 +++++++
 rtl/alu_exec_unit.sv | 104 ++++++++++
 tb/tb_alu_exec_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op codes (also used by CONTROL) and the multiplier state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue port from CONTROL into the execution unit.
// An instruction transfers on a posedge where issue_valid & issue_ready are both high;
// the master holds all issue_* fields stable while valid is high and not yet accepted.
interface alu_exec_unit_if;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_alu_ctrl;
  logic       issue_regwrite;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic [4:0] issue_rd;

  modport master (
    output issue_valid, issue_alu_ctrl, issue_regwrite, issue_rs1, issue_rs2, issue_rd,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_alu_ctrl, issue_regwrite, issue_rs1, issue_rs2, issue_rd,
    output issue_ready
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, XLEN cycles,
// low XLEN bits of the product kept. done/product are valid in the final RUN cycle.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product,
  output mul_state_e      state
);

  localparam int CW = $clog2(XLEN);

  mul_state_e      state_next;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MUL_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MUL_IDLE: if (start) state_next = MUL_RUN;
      MUL_RUN:  if (cnt == '0) state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  // The final iteration's sum is presented directly so the top can write it on that edge.
  assign acc_next = acc + (b_q[0] ? a_q : '0);
  assign product  = acc_next;
  assign busy     = (state == MUL_RUN);
  assign done     = (state == MUL_RUN) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
    end else if (state == MUL_IDLE) begin
      if (start) begin
        cnt <= CW'(XLEN - 1);
        a_q <= a;
        b_q <= b;
        acc <= '0;
      end
    end else begin
      cnt <= cnt - 1'b1;
      a_q <= a_q << 1;
      b_q <= b_q >> 1;
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution unit: 32-entry register file, single-cycle ALU and an iterative multiplier.
// Single-cycle results write back on the accept edge; MUL writes back XLEN cycles later.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_unit_if.slave    issue,
  output logic              busy,
  output logic [XLEN-1:0]   result,
  output logic              result_valid,
  output logic              illegal_op,
  input  logic [4:0]        dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] alu_res;
  logic            accept;
  logic            is_illegal;
  logic            is_mul;

  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  mul_state_e      mul_state;
  logic [4:0]      mul_rd;
  logic            mul_we;

  assign issue.issue_ready = (mul_state == MUL_IDLE);
  assign busy              = mul_busy;
  assign accept            = issue.issue_valid && issue.issue_ready;
  assign is_illegal        = issue.issue_alu_ctrl[3];
  assign is_mul            = (issue.issue_alu_ctrl == ALU_MUL);
  assign mul_start         = accept && is_mul;

  assign rs1_val  = (issue.issue_rs1 == '0) ? '0 : regs[issue.issue_rs1];
  assign rs2_val  = (issue.issue_rs2 == '0) ? '0 : regs[issue.issue_rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  always_comb begin
    alu_res = '0;
    case (issue.issue_alu_ctrl)
      ALU_AND: alu_res = rs1_val & rs2_val;
      ALU_OR:  alu_res = rs1_val | rs2_val;
      ALU_ADD: alu_res = rs1_val + rs2_val;
      ALU_SLL: alu_res = rs1_val << rs2_val[SHW-1:0];
      ALU_SUB: alu_res = rs1_val - rs2_val;
      ALU_SRL: alu_res = rs1_val >> rs2_val[SHW-1:0];
      ALU_XOR: alu_res = rs1_val ^ rs2_val;
      default: alu_res = '0;
    endcase
  end

  alu_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (rs1_val),
    .b       (rs2_val),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product),
    .state   (mul_state)
  );

  // Accept and MUL completion never coincide: issue_ready is low until the done edge has passed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      illegal_op   <= 1'b0;
      mul_rd       <= '0;
      mul_we       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      illegal_op   <= 1'b0;
      if (accept && is_illegal) begin
        illegal_op <= 1'b1;
      end else if (accept && is_mul) begin
        mul_rd <= issue.issue_rd;
        mul_we <= issue.issue_regwrite;
      end else if (accept) begin
        result       <= alu_res;
        result_valid <= 1'b1;
        if (issue.issue_regwrite && (issue.issue_rd != '0)) regs[issue.issue_rd] <= alu_res;
      end else if (mul_done) begin
        result       <= mul_product;
        result_valid <= 1'b1;
        if (mul_we && (mul_rd != '0)) regs[mul_rd] <= mul_product;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset, table of back-to-back single-cycle ops,
// MUL latency/stall sequence and reset-abort of a running MUL.
module tb_alu_exec_unit;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_BAD = 4'b1010;

  typedef struct {
    logic [3:0]  ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] exp_res;
    logic        exp_rv;
    logic        exp_ill;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        illegal_op;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[$];
  vec_t        cur;
  logic [31:0] v;
  int          rv_n;
  int          bad;
  logic [31:0] held_mid;

  alu_exec_unit_if issue_if();

  alu_exec_unit #(.XLEN(32), .NREGS(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue        (issue_if),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .illegal_op   (illegal_op),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we);
    issue_if.issue_alu_ctrl = ctrl;
    issue_if.issue_rs1      = rs1;
    issue_if.issue_rs2      = rs2;
    issue_if.issue_rd       = rd;
    issue_if.issue_regwrite = we;
    issue_if.issue_valid    = 1'b1;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] val);
    dbg_addr = a;
    #1;
    val = dbg_data;
  endtask

  function automatic vec_t mk(input logic [3:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic we, input logic [31:0] exp_res,
                              input logic exp_rv, input logic exp_ill, input logic [31:0] exp_rd);
    vec_t t;
    t.ctrl = ctrl; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.we = we;
    t.exp_res = exp_res; t.exp_rv = exp_rv; t.exp_ill = exp_ill; t.exp_rd = exp_rd;
    return t;
  endfunction

  // scoreboard: every result_valid pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_result actual=%h expected=none @%0t", result, $time);
      end else begin
        check("sb_result", result, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n                   = 1'b1;
    issue_if.issue_valid    = 1'b0;
    issue_if.issue_alu_ctrl = '0;
    issue_if.issue_regwrite = 1'b0;
    issue_if.issue_rs1      = '0;
    issue_if.issue_rs2      = '0;
    issue_if.issue_rd       = '0;
    dbg_addr                = '0;

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("rst_result", result, 32'h0);
    check("rst_ready", {31'b0, issue_if.issue_ready}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_rv", {31'b0, result_valid}, 32'h0);
    check("rst_ill", {31'b0, illegal_op}, 32'h0);
    for (int r = 0; r < 32; r++) begin
      read_reg(r[4:0], v);
      check($sformatf("rst_reg_x%0d", r), v, 32'h0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // no immediates on this port: seed one register with 1 and build everything else from it
    dut.regs[31] <= 32'd1;
    #1;

    //            op      rs1 rs2 rd  we  result        rv  ill rd-value
    vecs.push_back(mk(OP_ADD, 31, 31,  1, 1, 32'd2,        1, 0, 32'd2));
    vecs.push_back(mk(OP_ADD,  1,  1,  1, 1, 32'd4,        1, 0, 32'd4));
    vecs.push_back(mk(OP_ADD,  1, 31,  1, 1, 32'd5,        1, 0, 32'd5));
    vecs.push_back(mk(OP_ADD,  1,  0,  2, 1, 32'd5,        1, 0, 32'd5));
    vecs.push_back(mk(OP_ADD,  1, 31,  1, 1, 32'd6,        1, 0, 32'd6));
    vecs.push_back(mk(OP_ADD,  1, 31,  1, 1, 32'd7,        1, 0, 32'd7));
    vecs.push_back(mk(OP_ADD,  1,  2,  3, 1, 32'd12,       1, 0, 32'd12));
    vecs.push_back(mk(OP_SUB,  2,  1,  4, 1, 32'hFFFFFFFE, 1, 0, 32'hFFFFFFFE));
    vecs.push_back(mk(OP_AND,  4,  1,  8, 1, 32'd6,        1, 0, 32'd6));
    vecs.push_back(mk(OP_OR,   8, 31,  9, 1, 32'd7,        1, 0, 32'd7));
    vecs.push_back(mk(OP_XOR,  4,  1, 10, 1, 32'hFFFFFFF9, 1, 0, 32'hFFFFFFF9));
    vecs.push_back(mk(OP_SLL, 31,  2, 12, 1, 32'd32,       1, 0, 32'd32));
    vecs.push_back(mk(OP_ADD, 12,  2, 13, 1, 32'h25,       1, 0, 32'h25));
    vecs.push_back(mk(OP_SLL, 31, 13,  5, 1, 32'd32,       1, 0, 32'd32));
    vecs.push_back(mk(OP_SUB, 12, 31, 15, 1, 32'd31,       1, 0, 32'd31));
    vecs.push_back(mk(OP_SLL, 31, 15, 14, 1, 32'h80000000, 1, 0, 32'h80000000));
    vecs.push_back(mk(OP_SRL, 14, 15, 16, 1, 32'd1,        1, 0, 32'd1));
    vecs.push_back(mk(OP_SLL,  1, 12, 17, 1, 32'd7,        1, 0, 32'd7));
    vecs.push_back(mk(OP_SRL, 12, 31, 21, 1, 32'd16,       1, 0, 32'd16));
    vecs.push_back(mk(OP_SLL, 31, 21, 20, 1, 32'h00010000, 1, 0, 32'h00010000));
    vecs.push_back(mk(OP_ADD, 20, 31, 22, 1, 32'h00010001, 1, 0, 32'h00010001));
    vecs.push_back(mk(OP_BAD,  1,  2,  7, 1, 32'h00010001, 0, 1, 32'h0));
    vecs.push_back(mk(OP_ADD,  1,  2,  0, 1, 32'd12,       1, 0, 32'h0));
    vecs.push_back(mk(OP_ADD,  3,  3, 18, 0, 32'd24,       1, 0, 32'h0));
    vecs.push_back(mk(OP_ADD,  4, 31, 19, 1, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF));
    vecs.push_back(mk(OP_ADD, 19, 31, 19, 1, 32'h0,        1, 0, 32'h0));

    // back-to-back issue: valid stays high across the whole table
    for (int i = 0; i < vecs.size(); i++) begin
      cur = vecs[i];
      drive(cur.ctrl, cur.rs1, cur.rs2, cur.rd, cur.we);
      if (cur.exp_rv) exp_q.push_back(cur.exp_res);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rv", i), {31'b0, result_valid}, {31'b0, cur.exp_rv});
      check($sformatf("v%0d_ill", i), {31'b0, illegal_op}, {31'b0, cur.exp_ill});
      check($sformatf("v%0d_result", i), result, cur.exp_res);
      read_reg(cur.rd, v);
      check($sformatf("v%0d_reg_x%0d", i, cur.rd), v, cur.exp_rd);
    end

    // MUL x6 = 0x10000 * 0x10001, with an ADD held on the port while busy
    drive(OP_MUL, 20, 22, 6, 1);
    exp_q.push_back(32'h00010000);
    @(posedge clk);
    #1;
    check("mul_busy_after_accept", {31'b0, busy}, 32'h1);
    check("mul_ready_after_accept", {31'b0, issue_if.issue_ready}, 32'h0);
    check("mul_rv_after_accept", {31'b0, result_valid}, 32'h0);
    drive(OP_ADD, 20, 31, 23, 1);
    exp_q.push_back(32'h00010001);
    dbg_addr = 5'd23;
    rv_n     = 0;
    bad      = 0;
    held_mid = 32'hDEADBEEF;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) begin
        rv_n = n;
        break;
      end
      if (busy !== 1'b1 || issue_if.issue_ready !== 1'b0) bad++;
      if (n == 16) held_mid = dbg_data;
    end
    check("mul_rv_latency", rv_n, 32);
    check("mul_busy_window", bad, 0);
    check("mul_held_not_taken", held_mid, 32'h0);
    check("mul_result", result, 32'h00010000);
    check("mul_busy_clear", {31'b0, busy}, 32'h0);
    check("mul_ready_back", {31'b0, issue_if.issue_ready}, 32'h1);
    read_reg(5'd6, v);
    check("mul_reg_x6", v, 32'h00010000);
    @(posedge clk);
    #1;
    issue_if.issue_valid = 1'b0;
    check("held_rv", {31'b0, result_valid}, 32'h1);
    check("held_result", result, 32'h00010001);
    read_reg(5'd23, v);
    check("held_reg_x23", v, 32'h00010001);

    // reset during MUL cycle 10 aborts it
    drive(OP_MUL, 20, 22, 6, 1);
    @(posedge clk);
    #1 issue_if.issue_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("abort_busy_before", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_ready", {31'b0, issue_if.issue_ready}, 32'h1);
    check("abort_result", result, 32'h0);
    check("abort_rv", {31'b0, result_valid}, 32'h0);
    read_reg(5'd6, v);
    check("abort_reg_x6", v, 32'h0);
    read_reg(5'd3, v);
    check("abort_reg_x3", v, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_no_completion", bad, 0);
    read_reg(5'd6, v);
    check("abort_reg_x6_late", v, 32'h0);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
